// File: rtl/i2c_slave_rx_if.sv
// Bus-side pins and received-byte outputs of the write-only I2C target.
interface i2c_slave_rx_if;
    logic       i2c_scl;
    logic       i2c_sda;
    logic       sda_pull_low;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_hit;
    logic       busy;
    logic [7:0] byte_count;

    modport slave (
        input  i2c_scl, i2c_sda,
        output sda_pull_low, rx_data, rx_valid, addr_hit, busy, byte_count
    );

    modport master (
        output i2c_scl, i2c_sda,
        input  sda_pull_low, rx_data, rx_valid, addr_hit, busy, byte_count
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: matches DEV_ADDR, ACKs address and data, emits each byte with a 1-clk strobe.
// Pin-to-event latency SYNC_STAGES+1 clk; no downstream backpressure, every byte is strobed once.
module i2c_slave_rx #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    i2c_slave_rx_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    state_t                 state_q, state_d;
    logic [7:0]             sr_q, sr_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   addr_hit_q, addr_hit_d;
    logic                   busy_q, busy_d;
    logic [7:0]             byte_count_q, byte_count_d;
    logic                   pull_q, pull_d;

    logic scl_s, sda_s, scl_rise, scl_fall, start_evt, stop_evt;

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.i2c_scl};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.i2c_sda};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    // SCL must be high in both samples so an SDA move at an SCL edge is not a condition
    assign start_evt  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_evt   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        addr_hit_d   = 1'b0;
        byte_count_d = byte_count_q;
        pull_d       = pull_q;

        if (start_evt) begin
            state_d      = ADDR;
            bit_cnt_d    = 3'd0;
            byte_count_d = 8'd0;
            pull_d       = 1'b0;
        end else if (stop_evt) begin
            state_d = IDLE;
            pull_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    if (scl_rise) begin
                        sr_d      = {sr_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == DATA) begin
                                rx_data_d    = sr_d;
                                rx_valid_d   = 1'b1;
                                byte_count_d = (byte_count_q == 8'hFF) ? 8'hFF : byte_count_q + 8'd1;
                                state_d      = DATA_ACK;
                            end else if (sr_d[7:1] == DEV_ADDR && !sr_d[0]) begin
                                addr_hit_d = 1'b1;
                                state_d    = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // First fall opens the ACK window, the second (end of 9th clock) closes it
                    if (scl_fall) begin
                        if (!pull_q) begin
                            pull_d = 1'b1;
                        end else begin
                            pull_d    = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= IDLE;
            sr_q         <= 8'd0;
            bit_cnt_q    <= 3'd0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            addr_hit_q   <= 1'b0;
            busy_q       <= 1'b0;
            byte_count_q <= 8'd0;
            pull_q       <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_s;
            sda_prev_q   <= sda_s;
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            addr_hit_q   <= addr_hit_d;
            busy_q       <= busy_d;
            byte_count_q <= byte_count_d;
            pull_q       <= pull_d;
        end
    end

    assign bus.sda_pull_low = pull_q;
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.addr_hit     = addr_hit_q;
    assign bus.busy         = busy_q;
    assign bus.byte_count   = byte_count_q;
endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Write-only I2C target: the receive stage directly downstream of the team's I2C master write FSM.
- Samples the bus pins SCL and SDA with its own faster system clock and detects START and STOP.
- Decodes the 7-bit address and acknowledges it when it matches, then captures each following data byte and acknowledges it.
- Presents each captured byte on a parallel output with a one-cycle valid strobe. This is the on-chip model/target for the master's address 0x50 write of 0xAA.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address to acknowledge.
- SYNC_STAGES, 2, number of synchronizer flops on each of SCL and SDA (minimum 2).

Ports:
- clk  input  1  system clock; must run at least 8x the SCL frequency.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- i2c_scl  input  1  bus SCL, asynchronous to clk.
- i2c_sda  input  1  bus SDA, asynchronous to clk.
- sda_pull_low  output  1  1 = drive SDA low (open-drain enable); 0 = release.
- rx_data  output  8  last received data byte, MSB first on the bus.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- addr_hit  output  1  one-clk pulse when the address byte matches with R/W=0.
- busy  output  1  high from START until STOP or return to IDLE.
- byte_count  output  8  data bytes received since the last START; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sda_pull_low=0, rx_data=0, rx_valid=0, addr_hit=0, busy=0, byte_count=0, shift register=0, bit counter=0.
  - Synchronizer flops reset to 1 (idle bus).
- Synchronization:
  - Each pin passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - Edge and condition latency from pin to internal event is SYNC_STAGES+1 clk.
- Bus events (on synchronized signals):
  - scl_rise / scl_fall: SCL 0->1 / 1->0.
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
  - START and STOP take priority over any bit event in the same clk.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: on START -> ADDR; bit counter=0, byte_count=0, busy=1.
  - ADDR: on each scl_rise, shift SDA into the shift register LSB (MSB first). On the 8th rise, bits[7:1] are the address and bit[0] is R/W.
    - If address == DEV_ADDR and R/W == 0: pulse addr_hit that clk and go to ADDR_ACK.
    - Otherwise go to IGNORE; no ACK, SDA is never driven.
  - ADDR_ACK: on the next scl_fall, set sda_pull_low=1. Hold through the 9th SCL high phase. On the following scl_fall, set sda_pull_low=0 and go to DATA with bit counter=0.
  - DATA: shift on each scl_rise. On the 8th rise:
    - load rx_data;
    - pulse rx_valid for 1 clk;
    - byte_count += 1, saturating at 255;
    - go to DATA_ACK.
  - DATA_ACK: same ACK timing as ADDR_ACK, then return to DATA.
  - IGNORE: sda_pull_low stays 0. Wait for START or STOP.
- From any non-IDLE state:
  - STOP -> IDLE: busy=0, sda_pull_low=0 in the same clk.
  - START (repeated start) -> ADDR: bit counter=0, byte_count=0, sda_pull_low=0.
- A partial byte aborted by START or STOP is discarded: no rx_valid, byte_count unchanged.
- sda_pull_low is asserted only inside the ACK window (ADDR_ACK / DATA_ACK). It changes only in the clk after a detected scl_fall, so SDA never changes while SCL is high.
- Reset asserted mid-transfer: sda_pull_low drops to 0 immediately and asynchronously. After reset release, the block ignores bus activity until the next START.

Test Plan:
- START, byte 0xA0 (addr 0x50, W), ACK slot, byte 0xAA, ACK slot, STOP:
  - addr_hit pulses once;
  - sda_pull_low=1 during both 9th-bit SCL-high phases;
  - rx_data=0xAA with one rx_valid pulse;
  - byte_count=1;
  - busy=0 after STOP.
- START, byte 0xA2 (addr 0x51), then data 0x55:
  - sda_pull_low never asserted;
  - no addr_hit and no rx_valid;
  - state IGNORE until STOP.
- START, byte 0xA1 (addr 0x50, R) -> no ACK, no addr_hit, IGNORE.
- START, 0xA0, then 0x12, 0x34, 0xFF, STOP:
  - three rx_valid pulses carrying 0x12, 0x34, 0xFF in order;
  - byte_count=3;
  - each byte ACKed.
- START, 0xA0, 4 bits of data, repeated START, 0xA0, 0x5A, STOP:
  - the partial byte produces no rx_valid;
  - byte_count ends at 1 with rx_data=0x5A.
- rst driven low while sda_pull_low=1 in DATA_ACK:
  - sda_pull_low=0 within the same clk, and all outputs take their reset values;
  - after release, no response until a new START.
